// File: rtl/reset_req_responder_pkg.sv
// Shared types and constants for the reset request responder.
package reset_req_responder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } rsp_state_e;

  localparam int DEF_ASSERT_CYCLES  = 8;
  localparam int DEF_RELEASE_CYCLES = 4;
  localparam int DEF_TIMEOUT_CYCLES = 256;

  // Wide enough to hold the largest terminal count of any state.
  function automatic int cnt_width(input int a, input int r, input int t);
    int m;
    m = a;
    if (r > m) m = r;
    if (t > m) m = t;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_req_responder_sync.sv
// Multi-flop synchroniser for a single asynchronous level.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk) begin
    if (reset) ff_q <= '0;
    else       ff_q <= {ff_q[STAGES-2:0], d};
  end

  assign q = ff_q[STAGES-1];

endmodule

// File: rtl/reset_req_responder.sv
// Responder side of the conduit reset-request handshake.
// Optional ACK-hold timeout enabled by defining REQ_TIMEOUT_EN.
module reset_req_responder
  import reset_req_responder_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int ASSERT_CYCLES  = DEF_ASSERT_CYCLES,
  parameter int RELEASE_CYCLES = DEF_RELEASE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic req_in,
  output logic reset_out,
  output logic ack_out,
  output logic busy,
  output logic done_pulse,
  output logic timeout_err
);

  localparam int CW = cnt_width(ASSERT_CYCLES, RELEASE_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CW-1:0] A_LAST = CW'(ASSERT_CYCLES - 1);
  localparam logic [CW-1:0] R_LAST = CW'(RELEASE_CYCLES - 1);

  rsp_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_s, armed;
  logic          reset_out_d, ack_d, busy_d, done_d;

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (req_in),
    .q    (req_s)
  );

`ifdef REQ_TIMEOUT_EN
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic timeout_q, timeout_d, arm_q, arm_d;

  // After a forced release the request must be seen low before it counts again.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_q <= 1'b0;
      arm_q     <= 1'b1;
    end else begin
      timeout_q <= timeout_d;
      arm_q     <= arm_d;
    end
  end

  assign armed       = arm_q;
  assign timeout_err = timeout_q;
`else
  assign armed       = 1'b1;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ASSERT;
      cnt_q      <= '0;
      reset_out  <= 1'b1;
      ack_out    <= 1'b0;
      busy       <= 1'b1;
      done_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      reset_out  <= reset_out_d;
      ack_out    <= ack_d;
      busy       <= busy_d;
      done_pulse <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef REQ_TIMEOUT_EN
    timeout_d = timeout_q;
    arm_d     = arm_q | ~req_s;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_s && armed) state_d = ASSERT;
      end
      ASSERT: begin
        if (cnt_q == A_LAST) begin
          state_d = req_s ? ACK : RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACK: begin
        if (!req_s) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
`ifdef REQ_TIMEOUT_EN
        else if (cnt_q == T_LAST) begin
          state_d   = RELEASE;
          cnt_d     = '0;
          timeout_d = 1'b1;
          arm_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RELEASE: begin
        if (cnt_q == R_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    reset_out_d = (state_d == ASSERT) || (state_d == ACK);
    ack_d       = (state_d == ACK);
    busy_d      = (state_d != IDLE);
    done_d      = (state_q == RELEASE) && (state_d == IDLE);
  end

endmodule

// File: tb/tb_reset_req_responder.sv
// Directed bench: expected output vectors queued per step, compared each cycle.
module tb_reset_req_responder;

  typedef struct {
    string      tag;
    logic [4:0] vec;
  } exp_t;

  // {reset_out, ack_out, busy, done_pulse, timeout_err}
  localparam logic [4:0] S_AS = 5'b10100;
  localparam logic [4:0] S_AK = 5'b11100;
  localparam logic [4:0] S_RL = 5'b00100;
  localparam logic [4:0] S_DN = 5'b00010;
  localparam logic [4:0] S_ID = 5'b00000;
  localparam logic [4:0] TE   = 5'b00001;

  logic clk = 1'b0;
  logic reset, req_in;
  logic reset_out, ack_out, busy, done_pulse, timeout_err;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  reset_req_responder #(
    .SYNC_STAGES   (2),
    .ASSERT_CYCLES (8),
    .RELEASE_CYCLES(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_in     (req_in),
    .reset_out  (reset_out),
    .ack_out    (ack_out),
    .busy       (busy),
    .done_pulse (done_pulse),
    .timeout_err(timeout_err)
  );

  task automatic push(input string tag, input int n, input logic [4:0] v);
    exp_t e;
    e.tag = tag;
    e.vec = v;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  // One clock per queued entry; outputs sampled 1 time unit after the edge.
  task automatic drain();
    exp_t       e;
    logic [4:0] obs;
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      e   = sb.pop_front();
      obs = {reset_out, ack_out, busy, done_pulse, timeout_err};
      checks++;
      assert (obs === e.vec) else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.vec);
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    req_in = 1'b0;

    // Power-on: 8 asserted cycles after reset falls, then release sequence.
    push("por_reset", 3, S_AS);
    drain();
    reset = 1'b0;
    push("por_assert", 7, S_AS);
    push("por_release", 4, S_RL);
    push("por_done", 1, S_DN);
    push("por_idle", 2, S_ID);
    drain();

    // Full handshake, request held 20 cycles.
    req_in = 1'b1;
    push("hs_sync", 2, S_ID);
    push("hs_assert", 8, S_AS);
    push("hs_ack", 10, S_AK);
    drain();
    req_in = 1'b0;
    push("hs_ack_tail", 2, S_AK);
    push("hs_release", 4, S_RL);
    push("hs_done", 1, S_DN);
    push("hs_idle", 1, S_ID);
    drain();

    // Short request still gets the full assertion and no ack.
    req_in = 1'b1;
    push("short_sync", 2, S_ID);
    drain();
    req_in = 1'b0;
    push("short_assert", 8, S_AS);
    push("short_release", 4, S_RL);
    push("short_done", 1, S_DN);
    push("short_idle", 1, S_ID);
    drain();

    // Re-request during RELEASE waits for IDLE.
    req_in = 1'b1;
    push("rr_sync", 2, S_ID);
    push("rr_assert", 8, S_AS);
    push("rr_ack", 3, S_AK);
    drain();
    req_in = 1'b0;
    push("rr_ack_tail", 2, S_AK);
    push("rr_release_a", 2, S_RL);
    drain();
    req_in = 1'b1;
    push("rr_release_b", 2, S_RL);
    push("rr_done", 1, S_DN);
    push("rr_reassert", 8, S_AS);
    push("rr_ack2", 2, S_AK);
    drain();

    // Reset mid-ACK restarts a full assertion from count 0.
    reset = 1'b1;
    push("mid_reset", 1, S_AS);
    drain();
    reset = 1'b0;
    push("mid_assert", 7, S_AS);
    push("mid_ack", 2, S_AK);
    drain();
    req_in = 1'b0;
    push("mid_ack_tail", 2, S_AK);
    push("mid_release", 4, S_RL);
    push("mid_done", 1, S_DN);
    push("mid_idle", 1, S_ID);
    drain();

`ifdef REQ_TIMEOUT_EN
    // Held request is force-released after 16 ACK cycles and must re-arm.
    req_in = 1'b1;
    push("to_sync", 2, S_ID);
    push("to_assert", 8, S_AS);
    push("to_ack", 16, S_AK);
    push("to_release", 4, S_RL | TE);
    push("to_done", 1, S_DN | TE);
    push("to_hold_idle", 4, S_ID | TE);
    drain();
    req_in = 1'b0;
    push("to_rearm", 5, S_ID | TE);
    drain();
    req_in = 1'b1;
    push("to_sync2", 2, S_ID | TE);
    push("to_assert2", 8, S_AS | TE);
    push("to_ack2", 2, S_AK | TE);
    drain();
    reset = 1'b1;
    push("to_clear", 1, S_AS);
    drain();
    reset = 1'b0;
    req_in = 1'b0;
`else
    // Without the timeout, ACK holds well past 16 cycles.
    req_in = 1'b1;
    push("hold_sync", 2, S_ID);
    push("hold_assert", 8, S_AS);
    push("hold_ack", 20, S_AK);
    drain();
    req_in = 1'b0;
    push("hold_ack_tail", 2, S_AK);
    push("hold_release", 4, S_RL);
    push("hold_done", 1, S_DN);
    push("hold_idle", 1, S_ID);
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
